transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/transmitter_if.sv | 12 +
 rtl/tx_fifo.sv | 63 ++++++
 rtl/transmitter.sv | 136 +++++++++++++
 tb/tb_transmitter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame constants and the
// bit-period helper that the receiver also uses.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START_BIT,
      ST_DATA_BITS,
      ST_STOP_BIT
   } tx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Clock cycles per serial bit, rounded down.
   function automatic int bit_period(input int clock_freq, input int baud);
      return clock_freq / baud;
   endfunction

endpackage

// File: rtl/transmitter_if.sv
// Byte-push side and serial output of the UART transmitter. A byte is offered
// whenever start=1 at a clock edge; it is taken only when full=0 at that edge.
interface transmitter_if;
   logic       start;
   logic [7:0] data_in;
   logic       busy;
   logic       full;
   logic       txd;

   modport master (output start, data_in, input busy, full, txd);
   modport slave  (input start, data_in, output busy, full, txd);
endinterface

// File: rtl/tx_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the oldest entry.
module tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers are exactly AW bits, so DEPTH being a power of two gives the wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/transmitter.sv
// UART 8N1 transmitter: queued bytes are serialised LSB first on txd, frames
// following each other with no idle gap while the FIFO has data.
import uart_pkg::*;

module transmitter #(
   parameter int BAUD       = 115200,
   parameter int CLOCK_FREQ = 25_500_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   transmitter_if.slave  tx
);

   localparam int BIT_PERIOD = bit_period(CLOCK_FREQ, BAUD);
   localparam int BCW        = $clog2(BIT_PERIOD);

   tx_state_t              state_q, state_d;
   logic [BCW-1:0]         baud_cnt_q, baud_cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [7:0]             shift_q, shift_d;
   logic                   txd_q, txd_d;

   logic                   fifo_pop;
   logic [7:0]             fifo_dout;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                   baud_last;

   tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx.start),
      .pop   (fifo_pop),
      .din   (tx.data_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign baud_last = (baud_cnt_q == BCW'(BIT_PERIOD - 1));

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      txd_d      = txd_q;
      fifo_pop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            txd_d      = 1'b1;
            baud_cnt_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               txd_d    = 1'b0;
               state_d  = ST_START_BIT;
            end
         end
         ST_START_BIT: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               txd_d      = shift_q[0];
               shift_d    = shift_q >> 1;
               state_d    = ST_DATA_BITS;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         ST_DATA_BITS: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                  txd_d   = 1'b1;
                  state_d = ST_STOP_BIT;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  txd_d     = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         ST_STOP_BIT: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               // Chain straight into the next start bit so frames abut.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  txd_d    = 1'b0;
                  state_d  = ST_START_BIT;
               end else begin
                  txd_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         default: begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
      end
   end

   assign tx.txd  = txd_q;
   assign tx.full = fifo_full;
   assign tx.busy = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for the UART transmitter at 10 clocks per bit with a
// 4-entry FIFO; frames on txd are captured cycle by cycle and compared to a model.
module tb_transmitter;

   localparam int P     = 10;
   localparam int FRAME = 10 * P;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [7:0] exp_q[$];

   transmitter_if tif ();

   transmitter #(
      .BAUD       (100_000),
      .CLOCK_FREQ (1_000_000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .tx  (tif.slave)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic logic [FRAME-1:0] exp_wave(input logic [7:0] b);
      logic [FRAME-1:0] w;
      int slot;
      for (int j = 0; j < FRAME; j++) begin
         slot = j / P;
         if (slot == 0)      w[j] = 1'b0;
         else if (slot == 9) w[j] = 1'b1;
         else                w[j] = b[slot-1];
      end
      return w;
   endfunction

   function automatic logic [7:0] decode(input logic [FRAME-1:0] w);
      logic [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = w[(k+1)*P + P/2];
      return b;
   endfunction

   // ---------------- driver / monitor tasks ----------------
   // Waits for the next falling txd, then records one frame of samples.
   task automatic capture_frame(input int max_wait, output int fall_cyc,
                                output logic [FRAME-1:0] wav, output int busy_hi,
                                output bit timed_out);
      timed_out = 1'b0;
      wav       = '1;
      busy_hi   = 0;
      fall_cyc  = -1;
      for (int w = 0; w < max_wait; w++) begin
         @(negedge clk);
         if (tif.txd === 1'b0) begin
            fall_cyc = cyc;
            break;
         end
      end
      if (fall_cyc < 0) begin
         timed_out = 1'b1;
         return;
      end
      wav[0] = tif.txd;
      if (tif.busy === 1'b1) busy_hi++;
      for (int j = 1; j < FRAME; j++) begin
         @(negedge clk);
         wav[j] = tif.txd;
         if (tif.busy === 1'b1) busy_hi++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int bad;
      rst = 1'b1;
      tif.start = 1'b0;
      tif.data_in = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if (tif.txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", tif.txd); end
      n_checks++;
      if (tif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", tif.busy); end
      n_checks++;
      if (tif.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", tif.full); end
      tif.start = 1'b1;
      tif.data_in = 8'hAA;
      @(negedge clk);
      tif.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (tif.txd !== 1'b1 || tif.busy !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL reset_push_ignored: %0d active cycles, expected 0", bad); end
   endtask

   task automatic test_single();
      int e, fall, bh;
      logic [FRAME-1:0] wav;
      logic [7:0] exp;
      bit to;
      @(negedge clk);
      tif.start = 1'b1;
      tif.data_in = 8'h55;
      exp_q.push_back(8'h55);
      @(negedge clk);
      e = cyc;
      tif.start = 1'b0;
      n_checks++;
      if (tif.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b expected 1", tif.busy); end
      n_checks++;
      if (tif.txd !== 1'b1) begin n_fail++; $display("FAIL single_txd_at_E: got %b expected 1", tif.txd); end
      capture_frame(20, fall, wav, bh, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL single_timeout: no start bit seen"); end
      exp = exp_q.pop_front();
      n_checks++;
      if (fall != e + 1) begin n_fail++; $display("FAIL single_fall: got cycle %0d expected %0d", fall, e + 1); end
      n_checks++;
      if (wav !== exp_wave(exp)) begin n_fail++; $display("FAIL single_wave: got %h expected %h", wav, exp_wave(exp)); end
      n_checks++;
      if (decode(wav) !== exp) begin n_fail++; $display("FAIL single_byte: got %h expected %h", decode(wav), exp); end
      n_checks++;
      if (tif.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_E100: got %b expected 1", tif.busy); end
      @(negedge clk);
      n_checks++;
      if (tif.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b expected 0 at cycle %0d", tif.busy, cyc); end
   endtask

   task automatic test_back_to_back();
      int e, fall[2], bh[2];
      logic [FRAME-1:0] wav[2];
      logic [7:0] exp;
      bit to[2];
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      fork
         begin
            @(negedge clk);
            tif.start = 1'b1;
            tif.data_in = 8'hA5;
            e = cyc + 1;
            @(negedge clk);
            tif.data_in = 8'h3C;
            @(negedge clk);
            tif.start = 1'b0;
         end
         begin
            capture_frame(20, fall[0], wav[0], bh[0], to[0]);
            capture_frame(1, fall[1], wav[1], bh[1], to[1]);
         end
      join
      for (int k = 0; k < 2; k++) begin
         exp = exp_q.pop_front();
         n_checks++;
         if (to[k]) begin n_fail++; $display("FAIL b2b_timeout%0d: start bit missing", k); end
         n_checks++;
         if (fall[k] != e + 1 + k * FRAME) begin n_fail++; $display("FAIL b2b_fall%0d: got %0d expected %0d", k, fall[k], e + 1 + k * FRAME); end
         n_checks++;
         if (wav[k] !== exp_wave(exp)) begin n_fail++; $display("FAIL b2b_wave%0d: got %h expected %h", k, wav[k], exp_wave(exp)); end
      end
      n_checks++;
      if (bh[0] + bh[1] != 2 * FRAME) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", bh[0] + bh[1], 2 * FRAME); end
      @(negedge clk);
      n_checks++;
      if (tif.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_fall: got %b expected 0", tif.busy); end
   endtask

   task automatic test_overflow();
      int e, fall[5], bh[5], bad;
      logic [FRAME-1:0] wav[5];
      logic [7:0] exp;
      bit to[5];
      for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
      fork
         begin
            for (int i = 0; i < 7; i++) begin
               @(negedge clk);
               if (i == 4) begin
                  n_checks++;
                  if (tif.full !== 1'b0) begin n_fail++; $display("FAIL ovf_full_at3: got %b expected 0", tif.full); end
               end
               if (i == 5) begin
                  n_checks++;
                  if (tif.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_at4: got %b expected 1", tif.full); end
               end
               if (i == 0) e = cyc + 1;
               tif.start = 1'b1;
               tif.data_in = 8'(i + 1);
            end
            @(negedge clk);
            tif.start = 1'b0;
            n_checks++;
            if (tif.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_hold: got %b expected 1", tif.full); end
         end
         begin
            capture_frame(20, fall[0], wav[0], bh[0], to[0]);
            for (int k = 1; k < 5; k++) capture_frame(1, fall[k], wav[k], bh[k], to[k]);
         end
      join
      for (int k = 0; k < 5; k++) begin
         exp = exp_q.pop_front();
         n_checks++;
         if (to[k] || fall[k] != e + 1 + k * FRAME) begin n_fail++; $display("FAIL ovf_fall%0d: got %0d expected %0d", k, fall[k], e + 1 + k * FRAME); end
         n_checks++;
         if (decode(wav[k]) !== exp || wav[k] !== exp_wave(exp)) begin n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", k, decode(wav[k]), exp); end
      end
      bad = 0;
      repeat (150) begin
         @(negedge clk);
         if (tif.txd !== 1'b1 || tif.busy !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL ovf_dropped_bytes_sent: %0d active cycles expected 0", bad); end
   endtask

   task automatic test_simul_pushpop();
      int e, fall[3], bh[3];
      logic [FRAME-1:0] wav[3];
      logic [7:0] exp;
      bit to[3];
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'hC3);
      fork
         begin
            @(negedge clk);
            tif.start = 1'b1;
            tif.data_in = 8'h11;
            e = cyc + 1;
            @(negedge clk);
            tif.data_in = 8'h22;
            @(negedge clk);
            tif.start = 1'b0;
            while (cyc < e + FRAME) @(negedge clk);
            // Lands on the last stop cycle of the first frame, alongside its pop.
            tif.start = 1'b1;
            tif.data_in = 8'hC3;
            @(negedge clk);
            tif.start = 1'b0;
            n_checks++;
            if (tif.full !== 1'b0 || tif.busy !== 1'b1) begin n_fail++; $display("FAIL pp_flags: got full=%b busy=%b expected 0/1", tif.full, tif.busy); end
         end
         begin
            capture_frame(20, fall[0], wav[0], bh[0], to[0]);
            for (int k = 1; k < 3; k++) capture_frame(1, fall[k], wav[k], bh[k], to[k]);
         end
      join
      for (int k = 0; k < 3; k++) begin
         exp = exp_q.pop_front();
         n_checks++;
         if (to[k] || fall[k] != e + 1 + k * FRAME) begin n_fail++; $display("FAIL pp_fall%0d: got %0d expected %0d", k, fall[k], e + 1 + k * FRAME); end
         n_checks++;
         if (wav[k] !== exp_wave(exp)) begin n_fail++; $display("FAIL pp_wave%0d: got %h expected %h", k, wav[k], exp_wave(exp)); end
      end
      @(negedge clk);
      n_checks++;
      if (tif.busy !== 1'b0) begin n_fail++; $display("FAIL pp_busy_fall: got %b expected 0", tif.busy); end
   endtask

   task automatic test_reset_mid();
      int e, fall, bh;
      logic [FRAME-1:0] wav;
      logic [7:0] exp;
      bit to;
      @(negedge clk);
      tif.start = 1'b1;
      tif.data_in = 8'hFF;
      exp_q.push_back(8'hFF);
      e = cyc + 1;
      @(negedge clk);
      tif.start = 1'b0;
      while (cyc < e + 45) @(negedge clk);
      n_checks++;
      if (tif.busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", tif.busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp = exp_q.pop_front();
      n_checks++;
      if (tif.txd !== 1'b1 || tif.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_abort: got txd=%b busy=%b expected 1/0 (byte %h)", tif.txd, tif.busy, exp); end
      exp_q.push_back(8'h00);
      fork
         begin
            @(negedge clk);
            tif.start = 1'b1;
            tif.data_in = 8'h00;
            e = cyc + 1;
            @(negedge clk);
            tif.start = 1'b0;
         end
         capture_frame(20, fall, wav, bh, to);
      join
      exp = exp_q.pop_front();
      n_checks++;
      if (to || fall != e + 1) begin n_fail++; $display("FAIL rmid_fall: got %0d expected %0d", fall, e + 1); end
      n_checks++;
      if (wav !== exp_wave(exp)) begin n_fail++; $display("FAIL rmid_wave: got %h expected %h", wav, exp_wave(exp)); end
      n_checks++;
      if (bh != FRAME) begin n_fail++; $display("FAIL rmid_busy_cycles: got %0d expected %0d", bh, FRAME); end
      @(negedge clk);
      n_checks++;
      if (tif.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_fall: got %b expected 0", tif.busy); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      tif.start = 1'b0;
      tif.data_in = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_simul_pushpop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
